// File: rtl/cws_pkg.sv
// Shared types for the count-window scheduler: FSM state encoding and channel-index width helper.
package cws_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_counter.sv
// Saturating event counter with synchronous clear and sticky overflow; 1-cycle update, no backpressure.
module event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (en) begin
      // Hold at all-ones; any further event marks the window as saturated.
      if (&count) overflow <= 1'b1;
      else        count    <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_window_sched.sv
// Round-robin shares one event counter across channels; grant 1 cycle after req, result window_len+1 cycles
// after grant, held on res_* until res_ready.
module count_window_sched
  import cws_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int COUNT_WIDTH = 32,
  parameter  int WIN_WIDTH   = 16,
  localparam int CH_IDX_W    = ch_idx_w(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      req,
  input  logic [NUM_CH-1:0]      events,
  input  logic [WIN_WIDTH-1:0]   window_len,
  output logic [NUM_CH-1:0]      grant,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CH_IDX_W-1:0]    res_ch,
  output logic [COUNT_WIDTH-1:0] res_count,
  output logic                   res_overflow
);

  state_t                state;
  logic [CH_IDX_W-1:0]   rr_ptr;
  logic [CH_IDX_W-1:0]   cur_ch;
  logic [CH_IDX_W-1:0]   nxt_ch;
  logic [CH_IDX_W-1:0]   pick_ch;
  logic                  pick_vld;
  logic [CH_IDX_W:0]     scan;
  logic [WIN_WIDTH-1:0]  win_cnt;
  logic                  ec_clr;
  logic                  ec_en;

  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    scan     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = {1'b0, rr_ptr} + (CH_IDX_W+1)'(i);
      if (scan >= (CH_IDX_W+1)'(NUM_CH)) scan = scan - (CH_IDX_W+1)'(NUM_CH);
      if (!pick_vld && req[scan[CH_IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_ch  = scan[CH_IDX_W-1:0];
      end
    end
  end

  assign nxt_ch = (cur_ch == CH_IDX_W'(NUM_CH-1)) ? '0 : cur_ch + CH_IDX_W'(1);

  // The zero-count cycle at the end of COUNT is the hand-off to REPORT, not a sample.
  assign ec_clr = (state == IDLE) && pick_vld;
  assign ec_en  = (state == COUNT) && (win_cnt != '0) && events[cur_ch];

  event_counter #(.WIDTH(COUNT_WIDTH)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ec_clr),
    .en       (ec_en),
    .count    (res_count),
    .overflow (res_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      grant     <= '0;
      win_cnt   <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cur_ch  <= pick_ch;
            grant   <= NUM_CH'(1) << pick_ch;
            win_cnt <= window_len;
            state   <= COUNT;
          end
        end
        COUNT: begin
          if (!req[cur_ch]) begin
            grant  <= '0;
            rr_ptr <= nxt_ch;
            state  <= IDLE;
          end else if (win_cnt == '0) begin
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            win_cnt <= win_cnt - WIN_WIDTH'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            grant     <= '0;
            rr_ptr    <= nxt_ch;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign res_ch = cur_ch;

endmodule

// File: tb/tb_count_window_sched.sv
// Directed bench for count_window_sched with a result scoreboard; a second instance uses a 4-bit counter.
module tb_count_window_sched;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  events;
  logic [15:0] window_len;
  logic        res_ready;

  logic [3:0]  a_grant, b_grant;
  logic        a_busy, b_busy;
  logic        a_res_valid, b_res_valid;
  logic [1:0]  a_res_ch, b_res_ch;
  logic [31:0] a_res_count;
  logic [3:0]  b_res_count;
  logic        a_res_overflow, b_res_overflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  count_window_sched #(.NUM_CH(4), .COUNT_WIDTH(32), .WIN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .events(events), .window_len(window_len),
    .grant(a_grant), .busy(a_busy), .res_valid(a_res_valid), .res_ready(res_ready),
    .res_ch(a_res_ch), .res_count(a_res_count), .res_overflow(a_res_overflow)
  );

  count_window_sched #(.NUM_CH(4), .COUNT_WIDTH(4), .WIN_WIDTH(16)) dut_small (
    .clk(clk), .rst_n(rst_n), .req(req), .events(events), .window_len(window_len),
    .grant(b_grant), .busy(b_busy), .res_valid(b_res_valid), .res_ready(res_ready),
    .res_ch(b_res_ch), .res_count(b_res_count), .res_overflow(b_res_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (a_res_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 64'(a_res_valid), 64'(1));
  endtask

  task automatic wait_grant(input string tag, input int max, output int n);
    n = 0;
    while (a_grant === 4'b0000 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 64'(a_grant !== 4'b0000), 64'(1));
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, "_ch"},  64'(a_res_ch),       64'(e.ch));
      chk({tag, "_cnt"}, 64'(a_res_count),    64'(e.cnt));
      chk({tag, "_ovf"}, 64'(a_res_overflow), 64'(e.ovf));
    end
  endtask

  initial begin
    logic [10:0] pat;
    logic [3:0]  prev_grant;
    int          rr_model;
    int          n;
    exp_t        e;

    rst_n = 1'b0; req = '0; events = '0; window_len = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_grant", 64'(a_grant), 64'(0));
    chk("rst_busy",  64'(a_busy), 64'(0));
    chk("rst_valid", 64'(a_res_valid), 64'(0));
    chk("rst_ch",    64'(a_res_ch), 64'(0));
    chk("rst_cnt",   64'(a_res_count), 64'(0));
    chk("rst_ovf",   64'(a_res_overflow), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single channel 2, 10-cycle window, 4 events inside it, one event just past it.
    req = 4'b0100; window_len = 16'd10;
    tick();
    chk("t1_grant", 64'(a_grant), 64'(4'b0100));
    chk("t1_busy",  64'(a_busy), 64'(1));
    e = '{ch: 2'd2, cnt: 32'd4, ovf: 1'b0}; sb.push_back(e);
    window_len = 16'd3;
    pat = 11'b1_0100110010;
    for (int k = 0; k < 11; k++) begin
      events = 4'b1011 | (pat[k] ? 4'b0100 : 4'b0000);
      tick();
      chk($sformatf("t1_valid_%0d", k), 64'(a_res_valid), 64'(k == 10));
    end
    events = '0; req = '0; res_ready = 1'b1;
    check_result("t1");
    tick();
    chk("t1_done_valid", 64'(a_res_valid), 64'(0));
    chk("t1_done_grant", 64'(a_grant), 64'(0));
    chk("t1_done_busy",  64'(a_busy), 64'(0));

    // All four requesting; rr pointer restarts at 0 after reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    rr_model = 0; prev_grant = '0;
    req = 4'b1111; window_len = 16'd2; res_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("t2_grant_seen_%0d", g), 10, n);
      chk($sformatf("t2_grant_lat_%0d", g), 64'(n), 64'(1));
      chk($sformatf("t2_grant_%0d", g), 64'(a_grant), 64'(4'b0001 << rr_model));
      chk($sformatf("t2_norepeat_%0d", g), 64'(a_grant != prev_grant), 64'(1));
      prev_grant = a_grant;
      e = '{ch: 2'(rr_model), cnt: 32'd0, ovf: 1'b0}; sb.push_back(e);
      wait_valid($sformatf("t2_valid_%0d", g), 10);
      check_result($sformatf("t2_%0d", g));
      if (g == 4) req = '0;
      tick();
      chk($sformatf("t2_idle_grant_%0d", g), 64'(a_grant), 64'(0));
      rr_model = (rr_model + 1) % 4;
    end

    // Zero-length window on channel 1.
    req = 4'b0010; window_len = 16'd0; events = 4'b0010; res_ready = 1'b0;
    tick();
    chk("t3_grant", 64'(a_grant), 64'(4'b0010));
    e = '{ch: 2'd1, cnt: 32'd0, ovf: 1'b0}; sb.push_back(e);
    tick();
    chk("t3_valid", 64'(a_res_valid), 64'(1));
    check_result("t3");
    res_ready = 1'b1; req = '0; events = '0;
    tick();
    chk("t3_done_valid", 64'(a_res_valid), 64'(0));

    // Saturation: 20 events into a 4-bit counter; the 32-bit instance counts all of them.
    req = 4'b0001; window_len = 16'd20; events = 4'b1111;
    tick();
    chk("t4_grant", 64'(a_grant), 64'(4'b0001));
    e = '{ch: 2'd0, cnt: 32'd20, ovf: 1'b0}; sb.push_back(e);
    wait_valid("t4_valid", 30);
    check_result("t4");
    chk("t4_small_valid", 64'(b_res_valid), 64'(1));
    chk("t4_small_grant", 64'(b_grant), 64'(4'b0001));
    chk("t4_small_ch",    64'(b_res_ch), 64'(0));
    chk("t4_small_cnt",   64'(b_res_count), 64'(4'hf));
    chk("t4_small_ovf",   64'(b_res_overflow), 64'(1));
    req = '0; events = '0;
    tick();

    // Result held through 5 stalled cycles; req drop and other traffic do not disturb it.
    req = 4'b1000; window_len = 16'd4; res_ready = 1'b0;
    tick();
    chk("t5_grant", 64'(a_grant), 64'(4'b1000));
    e = '{ch: 2'd3, cnt: 32'd2, ovf: 1'b0}; sb.push_back(e);
    for (int k = 0; k < 5; k++) begin
      events = (k == 0 || k == 2) ? 4'b1000 : 4'b0000;
      tick();
    end
    req = 4'b0111; events = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("t5_hold_valid_%0d", s), 64'(a_res_valid), 64'(1));
      chk($sformatf("t5_hold_grant_%0d", s), 64'(a_grant), 64'(4'b1000));
      chk($sformatf("t5_hold_cnt_%0d", s), 64'(a_res_count), 64'(2));
    end
    res_ready = 1'b1;
    check_result("t5");
    tick();
    chk("t5_done_grant", 64'(a_grant), 64'(0));
    window_len = 16'd10; events = '0;
    tick();
    chk("t5_next_grant", 64'(a_grant), 64'(4'b0001));

    // Abort channel 0 by dropping its req; the pointer moves on to channel 1.
    repeat (3) tick();
    req = 4'b0110;
    tick();
    chk("t6_abort_grant", 64'(a_grant), 64'(0));
    chk("t6_abort_busy",  64'(a_busy), 64'(0));
    chk("t6_abort_valid", 64'(a_res_valid), 64'(0));
    tick();
    chk("t6_after_abort_grant", 64'(a_grant), 64'(4'b0010));

    // Reset in the middle of channel 1's window.
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_grant", 64'(a_grant), 64'(0));
    chk("t7_rst_busy",  64'(a_busy), 64'(0));
    chk("t7_rst_valid", 64'(a_res_valid), 64'(0));
    chk("t7_rst_ch",    64'(a_res_ch), 64'(0));
    chk("t7_rst_cnt",   64'(a_res_count), 64'(0));
    repeat (2) tick();
    req = 4'b1000; window_len = 16'd3;
    rst_n = 1'b1;
    tick();
    chk("t7_grant_ch3", 64'(a_grant), 64'(4'b1000));
    e = '{ch: 2'd3, cnt: 32'd0, ovf: 1'b0}; sb.push_back(e);
    res_ready = 1'b1;
    wait_valid("t7_valid", 10);
    check_result("t7");
    req = 4'b1111;
    tick();
    tick();
    chk("t7_wrap_grant", 64'(a_grant), 64'(4'b0001));
    chk("t7_sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
